sdram_bus_arbiter: RTL and testbench

Round-robin arbiter that shares the single system-bus port of the SDRAM controller between NP requesters. It sits between the masters (CPU, DMA, video fetch, and so on) and the SDRAM chip wrapper. It grants the bus for one complete transaction at a time and holds the grant until every write beat or the read command has been accepted. A tag FIFO routes each returning read beat to the requester that issued it.

---
 rtl/sdram_bus_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_sdram_bus_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_bus_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port among NP masters, with a tag FIFO steering read returns.
// Define SDRAM_ARB_FIXED_PRIO_EN to make the lowest-index requester always win. TAG_DEPTH must be a power of 2, >= 2.
module sdram_bus_arbiter #(
    parameter int NP        = 2,
    parameter int AW        = 24,
    parameter int DW        = 16,
    parameter int TAG_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NP-1:0]     m_read,
    input  logic [NP-1:0]     m_write,
    input  logic [NP*AW-1:0]  m_addr,
    input  logic [NP-1:0]     m_burst,
    input  logic [NP*3-1:0]   m_burst_len,
    input  logic [NP*DW-1:0]  m_wdata,
    input  logic [NP*2-1:0]   m_byteenable,
    output logic [NP-1:0]     m_ready,
    output logic [NP-1:0]     m_rvalid,
    output logic [DW-1:0]     m_rdata,
    output logic              bus_read,
    output logic              bus_write,
    output logic              bus_burst,
    output logic [AW-1:0]     bus_addr,
    output logic [2:0]        bus_burst_len,
    output logic [DW-1:0]     bus_wdata,
    output logic [1:0]        bus_byteenable,
    input  logic              bus_ready,
    input  logic              bus_rvalid,
    input  logic [DW-1:0]     bus_rdata
);

    localparam int PW  = (NP > 1) ? $clog2(NP) : 1;
    localparam int AIW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  gnt_q, gnt_d;
    logic [PW-1:0]  last_q, last_d;
    logic [3:0]     beats_left_q, beats_left_d;

    logic [PW-1:0]  tag_port_q  [TAG_DEPTH];
    logic [3:0]     tag_beats_q [TAG_DEPTH];
    logic [AIW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AIW:0]   count_q;
    logic           ret_active_q;
    logic [3:0]     ret_cnt_q;

    logic           fifo_empty, fifo_full;
    logic           rv_ok, pop, push, read_ok;
    logic           req_rd, req_wr;
    logic [PW-1:0]  head_port;
    logic [3:0]     head_beats, ret_rem;

    function automatic logic [3:0] beats_of(input logic burst, input logic [2:0] len);
        if (!burst)
            return 4'd1;
        if (len > 3'd3)
            return 4'd8;
        return 4'd1 << len;
    endfunction

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (AIW+1)'(TAG_DEPTH));
    assign head_port  = tag_port_q[rd_ptr_q];
    assign head_beats = tag_beats_q[rd_ptr_q];
    assign rv_ok      = bus_rvalid && !fifo_empty;
    // The return counter is only live after the head's first beat; before that the head's own count applies.
    assign ret_rem    = ret_active_q ? ret_cnt_q : head_beats;
    assign pop        = rv_ok && (ret_rem == 4'd1);
    assign read_ok    = !fifo_full || pop;
    assign req_rd     = m_read[gnt_q];
    assign req_wr     = m_write[gnt_q];
    assign push       = (state_q == S_GRANT) && bus_read && bus_ready;

    always_comb begin : return_route
        m_rvalid = '0;
        m_rdata  = '0;
        for (int unsigned i = 0; i < NP; i++)
            m_rvalid[i] = rv_ok && (head_port == PW'(i));
        if (rv_ok)
            m_rdata = bus_rdata;
    end

    always_comb begin : arb_next
        logic          found;
        logic [PW-1:0] win;
        int unsigned   idx;

        m_ready        = '0;
        bus_read       = 1'b0;
        bus_write      = 1'b0;
        bus_burst      = 1'b0;
        bus_addr       = '0;
        bus_burst_len  = '0;
        bus_wdata      = '0;
        bus_byteenable = '0;
        state_d        = state_q;
        gnt_d          = gnt_q;
        last_d         = last_q;
        beats_left_d   = beats_left_q;
        found          = 1'b0;
        win            = '0;
        idx            = 0;

        case (state_q)
            S_IDLE: begin
                for (int unsigned i = 0; i < NP; i++) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
                    idx = i;
`else
                    idx = int'(last_q) + 1 + i;
                    if (idx >= NP)
                        idx = idx - NP;
`endif
                    if (!found && (m_read[idx] || m_write[idx])) begin
                        found = 1'b1;
                        win   = PW'(idx);
                    end
                end
                if (found) begin
                    state_d      = S_GRANT;
                    gnt_d        = win;
                    beats_left_d = beats_of(m_burst[win], m_burst_len[int'(win)*3 +: 3]);
                end
            end
            S_GRANT: begin
                bus_burst      = m_burst[gnt_q];
                bus_addr       = m_addr[int'(gnt_q)*AW +: AW];
                bus_burst_len  = m_burst_len[int'(gnt_q)*3 +: 3];
                bus_wdata      = m_wdata[int'(gnt_q)*DW +: DW];
                bus_byteenable = m_byteenable[int'(gnt_q)*2 +: 2];
                bus_write      = req_wr;
                bus_read       = req_rd && read_ok;
                m_ready[gnt_q] = bus_ready && (req_wr || (req_rd && read_ok));
                if (req_wr && bus_ready) begin
                    beats_left_d = beats_left_q - 4'd1;
                    if (beats_left_q == 4'd1) begin
                        state_d = S_IDLE;
                        last_d  = gnt_q;
                    end
                end else if (req_rd && read_ok && bus_ready) begin
                    state_d = S_IDLE;
                    last_d  = gnt_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            gnt_q        <= '0;
            last_q       <= PW'(NP - 1);
            beats_left_q <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_q       <= last_d;
            beats_left_q <= beats_left_d;
        end
    end

    // Read transactions keep their beat count in beats_left_q, which is what gets tagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ret_active_q <= 1'b0;
            ret_cnt_q    <= '0;
        end else begin
            if (push) begin
                tag_port_q[wr_ptr_q]  <= gnt_q;
                tag_beats_q[wr_ptr_q] <= beats_left_q;
                wr_ptr_q              <= wr_ptr_q + AIW'(1);
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + AIW'(1);
            if (push && !pop)
                count_q <= count_q + (AIW+1)'(1);
            else if (pop && !push)
                count_q <= count_q - (AIW+1)'(1);
            if (rv_ok) begin
                ret_active_q <= !pop;
                ret_cnt_q    <= ret_rem - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_bus_arbiter.sv
// Directed bench for sdram_bus_arbiter: transaction-level queue model checked every cycle, plus literal expectations.
module tb_sdram_bus_arbiter;

    localparam int NP        = 2;
    localparam int AW        = 24;
    localparam int DW        = 16;
    localparam int TAG_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NP-1:0]     m_read = '0, m_write = '0, m_burst = '0;
    logic [NP*AW-1:0]  m_addr = '0;
    logic [NP*3-1:0]   m_burst_len = '0;
    logic [NP*DW-1:0]  m_wdata = '0;
    logic [NP*2-1:0]   m_byteenable = '0;
    logic [NP-1:0]     m_ready, m_rvalid;
    logic [DW-1:0]     m_rdata;
    logic              bus_read, bus_write, bus_burst;
    logic [AW-1:0]     bus_addr;
    logic [2:0]        bus_burst_len;
    logic [DW-1:0]     bus_wdata;
    logic [1:0]        bus_byteenable;
    logic              bus_ready = 1'b0, bus_rvalid = 1'b0;
    logic [DW-1:0]     bus_rdata = '0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sdram_bus_arbiter #(.NP(NP), .AW(AW), .DW(DW), .TAG_DEPTH(TAG_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_burst(m_burst),
        .m_burst_len(m_burst_len), .m_wdata(m_wdata), .m_byteenable(m_byteenable),
        .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .bus_read(bus_read), .bus_write(bus_write), .bus_burst(bus_burst),
        .bus_addr(bus_addr), .bus_burst_len(bus_burst_len), .bus_wdata(bus_wdata),
        .bus_byteenable(bus_byteenable), .bus_ready(bus_ready),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic rd, input logic wr, input logic burst,
                            input logic [2:0] len, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        m_read[p]              = rd;
        m_write[p]             = wr;
        m_burst[p]             = burst;
        m_burst_len[p*3 +: 3]  = len;
        m_addr[p*AW +: AW]     = addr;
        m_wdata[p*DW +: DW]    = wd;
        m_byteenable[p*2 +: 2] = (p == 0) ? 2'b11 : 2'b10;
    endtask

    task automatic clear_port(input int p);
        set_port(p, 1'b0, 1'b0, 1'b0, 3'd0, '0, '0);
    endtask

    // Returns at the falling edge of the cycle in which port p is accepted.
    task automatic wait_ready(input int p, input string name);
        bit ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (m_ready[p])
                ok = 1'b1;
            else
                tick();
        end
        check(name, ok, 1'b1);
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct {
        int port;
        int beats;
    } tag_t;

    tag_t tagq[$];
    bit   md_busy = 1'b0;
    int   md_port = 0, md_left = 0, md_last = NP - 1, md_done = 0;

    function automatic int beats_for(input logic burst, input logic [2:0] len);
        int tbl[8] = '{1, 2, 4, 8, 8, 8, 8, 8};
        return burst ? tbl[len] : 1;
    endfunction

    initial begin : compare
        logic [NP-1:0] e_ready, e_rvalid;
        logic [DW-1:0] e_rdata, e_wdata;
        logic          e_read, e_write, e_burst;
        logic [AW-1:0] e_addr;
        logic [2:0]    e_len;
        logic [1:0]    e_be;
        bit            pop_now, allowed;
        int            p, c;
        @(posedge clk);
        forever begin
            @(negedge clk);
            e_ready = '0; e_rvalid = '0; e_rdata = '0; e_wdata = '0;
            e_read = 1'b0; e_write = 1'b0; e_burst = 1'b0; e_addr = '0; e_len = '0; e_be = '0;
            pop_now = 1'b0;
            p = md_port;
            if (bus_rvalid && tagq.size() > 0) begin
                e_rvalid[tagq[0].port] = 1'b1;
                e_rdata = bus_rdata;
                pop_now = (md_done + 1 == tagq[0].beats);
            end
            if (md_busy) begin
                e_burst = m_burst[p];
                e_addr  = m_addr[p*AW +: AW];
                e_len   = m_burst_len[p*3 +: 3];
                e_wdata = m_wdata[p*DW +: DW];
                e_be    = m_byteenable[p*2 +: 2];
                if (m_write[p]) begin
                    e_write    = 1'b1;
                    e_ready[p] = bus_ready;
                end else if (m_read[p]) begin
                    allowed    = (tagq.size() < TAG_DEPTH) || pop_now;
                    e_read     = allowed;
                    e_ready[p] = bus_ready && allowed;
                end
            end
            tests++;
            if ({m_ready, m_rvalid, m_rdata, bus_read, bus_write, bus_burst, bus_addr, bus_burst_len, bus_wdata, bus_byteenable}
                !== {e_ready, e_rvalid, e_rdata, e_read, e_write, e_burst, e_addr, e_len, e_wdata, e_be}) begin
                fails++;
                $display("FAIL cycle_compare t=%0t: got %h expected %h", $time,
                    {m_ready, m_rvalid, m_rdata, bus_read, bus_write, bus_burst, bus_addr, bus_burst_len, bus_wdata, bus_byteenable},
                    {e_ready, e_rvalid, e_rdata, e_read, e_write, e_burst, e_addr, e_len, e_wdata, e_be});
            end
            // advance the model across the coming rising edge
            if (rst) begin
                tagq.delete();
                md_busy = 1'b0; md_left = 0; md_last = NP - 1; md_done = 0;
            end else begin
                if (bus_rvalid && tagq.size() > 0) begin
                    md_done++;
                    if (md_done == tagq[0].beats) begin
                        void'(tagq.pop_front());
                        md_done = 0;
                    end
                end
                if (md_busy) begin
                    if (e_write && bus_ready) begin
                        md_left--;
                        if (md_left == 0) begin
                            md_busy = 1'b0;
                            md_last = p;
                        end
                    end else if (e_read && bus_ready) begin
                        tagq.push_back(tag_t'{port: p, beats: md_left});
                        md_busy = 1'b0;
                        md_last = p;
                    end
                end else begin
                    for (int k = 1; k <= NP && !md_busy; k++) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
                        c = k - 1;
`else
                        c = (md_last + k) % NP;
`endif
                        if (m_read[c] || m_write[c]) begin
                            md_busy = 1'b1;
                            md_port = c;
                            md_left = beats_for(m_burst[c], m_burst_len[c*3 +: 3]);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus ----------------
    initial begin : stim
        int           g[$];
        int           hs;
        bit           early, raised;
        logic [NP-1:0] rv[3];
        logic [DW-1:0] rd[3];
        logic [DW-1:0] ret_data[3];

        ret_data = '{16'hAAAA, 16'hBBBB, 16'hCCCC};

        repeat (2) tick();
        @(negedge clk);
        check("reset_outputs",
              {m_ready, m_rvalid, m_rdata, bus_read, bus_write, bus_burst, bus_addr, bus_burst_len, bus_wdata, bus_byteenable}, '0);
        tick();
        rst = 1'b0;

        // single write from port 0
        set_port(0, 1'b0, 1'b1, 1'b0, 3'd0, 24'h000010, 16'h1234);
        bus_ready = 1'b1;
        @(negedge clk);
        check("t1_not_same_cycle", bus_write, 1'b0);
        tick();
        @(negedge clk);
        check("t1_bus_write", bus_write, 1'b1);
        check("t1_bus_addr", bus_addr, 24'h000010);
        check("t1_bus_wdata", bus_wdata, 16'h1234);
        check("t1_m_ready", m_ready, 2'b01);
        tick();
        clear_port(0);
        @(negedge clk);
        check("t1_back_idle", {bus_write, m_ready}, '0);

        // both ports request continuously: grants alternate
        tick();
        set_port(0, 1'b0, 1'b1, 1'b0, 3'd0, 24'h000020, 16'h0A0A);
        set_port(1, 1'b0, 1'b1, 1'b0, 3'd0, 24'h000030, 16'h0B0B);
        for (int c = 0; c < 20 && g.size() < 4; c++) begin
            @(negedge clk);
            if (m_ready != '0)
                g.push_back(m_ready[1] ? 1 : 0);
            if (g.size() < 4)
                tick();
        end
        tick();
        clear_port(0);
        clear_port(1);
        check("t2_grant_count", g.size(), 4);
        for (int i = 0; i < g.size(); i++)
            check("t2_grant_order", g[i], (i % 2 == 0) ? 1 : 0);

        // port 1 burst of 4 beats; port 0 raised mid-burst waits
        set_port(1, 1'b0, 1'b1, 1'b1, 3'd2, 24'h000040, 16'h4444);
        hs = 0; early = 1'b0; raised = 1'b0;
        for (int c = 0; c < 30 && hs < 4; c++) begin
            @(negedge clk);
            if (m_ready[0])
                early = 1'b1;
            if (m_ready[1])
                hs++;
            if (hs < 4) begin
                tick();
                if (hs >= 2 && !raised) begin
                    set_port(0, 1'b0, 1'b1, 1'b0, 3'd0, 24'h000050, 16'h5555);
                    raised = 1'b1;
                end
            end
        end
        check("t3_burst_beats", hs, 4);
        check("t3_no_early_grant", early, 1'b0);
        tick();
        clear_port(1);
        wait_ready(0, "t3_port0_after_burst");
        tick();
        clear_port(0);

        // reads: port 0 two-beat burst, then port 1 single; three returns
        set_port(0, 1'b1, 1'b0, 1'b1, 3'd1, 24'h000100, 16'h0000);
        wait_ready(0, "t4_read0_accept");
        tick();
        clear_port(0);
        set_port(1, 1'b1, 1'b0, 1'b0, 3'd0, 24'h000200, 16'h0000);
        wait_ready(1, "t4_read1_accept");
        tick();
        clear_port(1);
        for (int i = 0; i < 3; i++) begin
            bus_rvalid = 1'b1;
            bus_rdata  = ret_data[i];
            @(negedge clk);
            rv[i] = m_rvalid;
            rd[i] = m_rdata;
            tick();
        end
        bus_rvalid = 1'b0;
        check("t4_rvalid0", rv[0], 2'b01);
        check("t4_rdata0", rd[0], 16'hAAAA);
        check("t4_rvalid1", rv[1], 2'b01);
        check("t4_rdata1", rd[1], 16'hBBBB);
        check("t4_rvalid2", rv[2], 2'b10);
        check("t4_rdata2", rd[2], 16'hCCCC);

        // fill the tag FIFO, then a fifth read stalls until a return frees a slot
        set_port(0, 1'b1, 1'b0, 1'b0, 3'd0, 24'h000300, 16'h0000);
        hs = 0;
        for (int c = 0; c < 40 && hs < 4; c++) begin
            @(negedge clk);
            if (m_ready[0])
                hs++;
            tick();
        end
        check("t5_four_reads", hs, 4);
        tick();
        @(negedge clk);
        check("t5_full_bus_read", bus_read, 1'b0);
        check("t5_full_m_ready", m_ready, 2'b00);
        tick();
        bus_rvalid = 1'b1;
        bus_rdata  = 16'h1111;
        @(negedge clk);
        check("t5_free_bus_read", bus_read, 1'b1);
        check("t5_free_m_ready", m_ready, 2'b01);
        check("t5_free_rvalid", m_rvalid, 2'b01);
        tick();
        clear_port(0);
        for (int i = 0; i < 4; i++) begin
            bus_rdata = 16'h2000 + 16'(i);
            tick();
        end
        bus_rvalid = 1'b0;

        // reset during a write burst with a read outstanding
        set_port(1, 1'b1, 1'b0, 1'b0, 3'd0, 24'h000400, 16'h0000);
        wait_ready(1, "t6_read_accept");
        tick();
        clear_port(1);
        set_port(0, 1'b0, 1'b1, 1'b1, 3'd3, 24'h000500, 16'h6666);
        hs = 0;
        for (int c = 0; c < 20 && hs < 2; c++) begin
            @(negedge clk);
            if (m_ready[0])
                hs++;
            tick();
        end
        check("t6_two_beats", hs, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_port(0);
        bus_rvalid = 1'b1;
        bus_rdata  = 16'hDEAD;
        @(negedge clk);
        check("t6_outputs_zero",
              {m_ready, m_rvalid, m_rdata, bus_read, bus_write, bus_burst, bus_addr, bus_burst_len, bus_wdata, bus_byteenable}, '0);
        tick();
        bus_rvalid = 1'b0;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
